// File: rtl/ce_bridge_pkg.sv
// Shared types and helpers for the clock-enable handshake bridge.
// Holds the FSM state encoding and the width helpers used by the bridge and divider.
package ce_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_CHANNELS = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit index so vectors never collapse to zero width.
    function automatic int chan_idx_w(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/ce_handshake_bridge_if.sv
// Bundle of the fast-side request/ack signals and the slow-side strobe bus.
// The slave modport is the bridge view; the master modport is the environment driving it.
interface ce_handshake_bridge_if #(
    parameter int WIDTH    = 32,
    parameter int AWIDTH   = 8,
    parameter int CHANNELS = 2
);
    import ce_bridge_pkg::*;

    logic [CHANNELS-1:0]        f_read_i;
    logic [CHANNELS*AWIDTH-1:0] f_addr_i;
    logic [CHANNELS-1:0]        f_ack_o;
    logic [WIDTH-1:0]           f_data_o;
    logic                       f_err_o;
    logic                       s_ce_o;
    logic                       s_read_o;
    logic [AWIDTH-1:0]          s_addr_o;
    logic                       s_ready_i;
    logic [WIDTH-1:0]           s_data_i;
    state_t                     dbg_state;

    // Handshake: f_read_i is a level held until its one-clk f_ack_o pulse; s_ready_i/s_data_i
    // count only in a cycle where s_ce_o=1, and s_read_o/s_addr_o move only on strobe edges.
    modport slave (
        input  f_read_i, f_addr_i, s_ready_i, s_data_i,
        output f_ack_o, f_data_o, f_err_o, s_ce_o, s_read_o, s_addr_o, dbg_state
    );

    modport master (
        output f_read_i, f_addr_i, s_ready_i, s_data_i,
        input  f_ack_o, f_data_o, f_err_o, s_ce_o, s_read_o, s_addr_o, dbg_state
    );

endinterface

// File: rtl/ce_divider.sv
// Clock-enable generator: registered strobe high for one clk out of every RATIO.
// The first strobe appears in the RATIO-th clk after reset release.
module ce_divider
    import ce_bridge_pkg::*;
#(
    parameter int RATIO = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic s_ce
);

    localparam int CNTW = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(RATIO - 1);

    logic [CNTW-1:0] r_count;
    logic            r_ce;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ce    <= 1'b0;
        end else begin
            r_ce    <= (r_count == LAST);
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign s_ce = r_ce;

endmodule

// File: rtl/ce_handshake_bridge.sv
// Round-robin bridge from fast level-held read requests to a slow strobe-qualified target,
// with a timeout that answers the requester with an error instead of data.
module ce_handshake_bridge
    import ce_bridge_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AWIDTH   = 8,
    parameter int CHANNELS = 2,
    parameter int RATIO    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ce_handshake_bridge_if.slave  bus
);

    localparam int CW = chan_idx_w(CHANNELS);
    localparam int TW = clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_HIT  = TW'(TIMEOUT - 1);

    state_t              r_state;
    logic [CW-1:0]       r_rr;
    logic [CW-1:0]       r_grant;
    logic [TW-1:0]       r_tcnt;
    logic [CHANNELS-1:0] r_ack;
    logic [WIDTH-1:0]    r_data;
    logic                r_err;
    logic                r_sread;
    logic [AWIDTH-1:0]   r_saddr;

    logic                w_ce;
    logic                w_any;
    logic [CW-1:0]       w_grant;
    logic [CW-1:0]       w_rr_next;
    logic [AWIDTH-1:0]   w_addr;
    logic [CHANNELS-1:0] w_grant_oh;

    ce_divider #(
        .RATIO (RATIO)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .s_ce    (w_ce)
    );

    // Search upward from the rr pointer, wrapping; the first requester found wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_any && bus.f_read_i[CW'((int'(r_rr) + i) % CHANNELS)]) begin
                w_any   = 1'b1;
                w_grant = CW'((int'(r_rr) + i) % CHANNELS);
            end
        end
    end

    always_comb begin
        w_rr_next = (int'(w_grant) == CHANNELS - 1) ? '0 : w_grant + 1'b1;
        w_addr    = bus.f_addr_i[int'(w_grant)*AWIDTH +: AWIDTH];
    end

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_grant <= '0;
            r_tcnt  <= '0;
            r_ack   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_sread <= 1'b0;
            r_saddr <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_ce && w_any) begin
                        r_grant <= w_grant;
                        r_saddr <= w_addr;
                        r_sread <= 1'b1;
                        r_tcnt  <= '0;
                        r_rr    <= w_rr_next;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // The granted channel dropping its request here does not abort the read.
                    if (w_ce) begin
                        if (bus.s_ready_i) begin
                            r_data  <= bus.s_data_i;
                            r_err   <= 1'b0;
                            r_sread <= 1'b0;
                            r_ack   <= w_grant_oh;
                            r_state <= DONE;
                        end else begin
                            if (r_tcnt != TO_LAST) begin
                                r_tcnt <= r_tcnt + 1'b1;
                            end
                            if (r_tcnt == TO_HIT) begin
                                r_data  <= '0;
                                r_err   <= 1'b1;
                                r_sread <= 1'b0;
                                r_ack   <= w_grant_oh;
                                r_state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    // Holding here until the served request drops keeps it from being re-served.
                    if (!bus.f_read_i[r_grant]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.f_ack_o   = r_ack;
    assign bus.f_data_o  = r_data;
    assign bus.f_err_o   = r_err;
    assign bus.s_ce_o    = w_ce;
    assign bus.s_read_o  = r_sread;
    assign bus.s_addr_o  = r_saddr;
    assign bus.dbg_state = r_state;

endmodule
